// File: rtl/rgb_frame_loader_pkg.sv
// Constants and FSM encoding shared between the frame-buffer write side and the VGA read side.
package rgb_frame_loader_pkg;

  localparam int unsigned DefImgWidth   = 160;
  localparam int unsigned DefImgHeight  = 120;
  localparam int unsigned DefAddrWidth  = 15;
  localparam int unsigned DefColorBits  = 4;
  localparam int unsigned DefIdleTimeout = 104160;
  localparam int unsigned DefLedHold    = 2500000;

  // Which channel byte the loader is waiting for next.
  typedef enum logic [1:0] {
    ST_R = 2'd0,
    ST_G = 2'd1,
    ST_B = 2'd2
  } rx_state_e;

endpackage

// File: rtl/rx_activity_led.sv
// Retriggerable pulse stretcher: output stays high LED_HOLD clocks after the latest strobe.
module rx_activity_led
  import rgb_frame_loader_pkg::*;
#(
  parameter int unsigned LED_HOLD = DefLedHold
) (
  input  logic i_Clock,
  input  logic i_Reset_n,
  input  logic i_Strobe,
  output logic o_Led
);

  localparam int unsigned CntW = $clog2(LED_HOLD + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            led_q;

  always_comb begin
    cnt_d = cnt_q;
    if (i_Strobe) begin
      cnt_d = CntW'(LED_HOLD);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      cnt_q <= '0;
      led_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      led_q <= (cnt_d != '0);
    end
  end

  assign o_Led = led_q;

endmodule

// File: rtl/rgb_frame_loader.sv
// Assembles UART bytes R,G,B into packed pixels and writes them row-major into a frame buffer.
module rgb_frame_loader
  import rgb_frame_loader_pkg::*;
#(
  parameter int unsigned IMG_WIDTH    = DefImgWidth,
  parameter int unsigned IMG_HEIGHT   = DefImgHeight,
  parameter int unsigned ADDR_WIDTH   = DefAddrWidth,
  parameter int unsigned COLOR_BITS   = DefColorBits,
  parameter int unsigned IDLE_TIMEOUT = DefIdleTimeout,
  parameter int unsigned LED_HOLD     = DefLedHold
) (
  input  logic                    i_Clock,
  input  logic                    i_Reset_n,
  input  logic                    i_Rx_DV,
  input  logic [7:0]              i_Rx_Byte,
  output logic                    o_Wr_En,
  output logic [ADDR_WIDTH-1:0]   o_Wr_Addr,
  output logic [3*COLOR_BITS-1:0] o_Wr_Data,
  output logic                    o_Frame_Done,
  output logic                    o_Busy,
  output logic                    o_Sync_Err,
  output logic                    o_Rx_LED
);

  localparam int unsigned         NumPix  = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned         TmoW    = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TmoW-1:0]     TmoLast = TmoW'(IDLE_TIMEOUT - 1);
  localparam logic [TmoW-1:0]     TmoMax  = TmoW'(IDLE_TIMEOUT);
  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(NumPix - 1);

  rx_state_e                 state_q, state_d;
  logic [COLOR_BITS-1:0]     r_q, r_d, g_q, g_d;
  logic [ADDR_WIDTH-1:0]     idx_q, idx_d;
  logic [TmoW-1:0]           tmo_q, tmo_d;
  logic                      wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [3*COLOR_BITS-1:0]   data_q, data_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      busy_q, busy_d;
  logic [COLOR_BITS-1:0]     chan;
  logic                      unused_byte;

  assign chan        = i_Rx_Byte[7 -: COLOR_BITS];
  assign unused_byte = ^i_Rx_Byte;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    g_d     = g_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (i_Rx_DV) begin
      // A byte always wins over a timeout expiring in the same cycle.
      tmo_d = '0;
      unique case (state_q)
        ST_R: begin
          r_d     = chan;
          state_d = ST_G;
        end
        ST_G: begin
          g_d     = chan;
          state_d = ST_B;
        end
        ST_B: begin
          wr_en_d = 1'b1;
          addr_d  = idx_q;
          data_d  = {r_q, g_q, chan};
          state_d = ST_R;
          if (idx_q == LastIdx) begin
            done_d = 1'b1;
            idx_d  = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: state_d = ST_R;
      endcase
    end else if (state_q != ST_R) begin
      if (tmo_q >= TmoLast) begin
        state_d = ST_R;
        tmo_d   = '0;
        err_d   = 1'b1;
      end else if (tmo_q != TmoMax) begin
        tmo_d = tmo_q + 1'b1;
      end
    end
    busy_d = (idx_d != '0) || (state_d != ST_R);
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q <= ST_R;
      r_q     <= '0;
      g_q     <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      g_q     <= g_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  rx_activity_led #(
    .LED_HOLD(LED_HOLD)
  ) u_led (
    .i_Clock  (i_Clock),
    .i_Reset_n(i_Reset_n),
    .i_Strobe (i_Rx_DV),
    .o_Led    (o_Rx_LED)
  );

  assign o_Wr_En      = wr_en_q;
  assign o_Wr_Addr    = addr_q;
  assign o_Wr_Data    = data_q;
  assign o_Frame_Done = done_q;
  assign o_Busy       = busy_q;
  assign o_Sync_Err   = err_q;

endmodule

// File: tb/tb_rgb_frame_loader.sv
// Randomized bench for rgb_frame_loader against a byte-queue reference model.
module tb_rgb_frame_loader;

  localparam int unsigned W    = 4;
  localparam int unsigned H    = 2;
  localparam int unsigned AW   = 3;
  localparam int unsigned CB   = 4;
  localparam int unsigned TMO  = 50;
  localparam int unsigned HOLD = 20;
  localparam int          N    = W * H;

  logic          clk;
  logic          rst_n;
  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic          frame_done;
  logic          busy;
  logic          sync_err;
  logic          rx_led;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pending channel bytes, idle gap, pixels written, last strobe time.
  logic [7:0]    pend [2];
  int            have;
  int            gap;
  int            pix;
  int            edge_n;
  int            last_strobe;
  logic          exp_wr_en, exp_done, exp_err, exp_busy, exp_led;
  logic [AW-1:0] exp_addr;
  logic [11:0]   exp_data;

  rgb_frame_loader #(
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .ADDR_WIDTH  (AW),
    .COLOR_BITS  (CB),
    .IDLE_TIMEOUT(TMO),
    .LED_HOLD    (HOLD)
  ) dut (
    .i_Clock     (clk),
    .i_Reset_n   (rst_n),
    .i_Rx_DV     (rx_dv),
    .i_Rx_Byte   (rx_byte),
    .o_Wr_En     (wr_en),
    .o_Wr_Addr   (wr_addr),
    .o_Wr_Data   (wr_data),
    .o_Frame_Done(frame_done),
    .o_Busy      (busy),
    .o_Sync_Err  (sync_err),
    .o_Rx_LED    (rx_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    have        = 0;
    gap         = 0;
    pix         = 0;
    last_strobe = -1000000;
    exp_wr_en   = 1'b0;
    exp_done    = 1'b0;
    exp_err     = 1'b0;
    exp_busy    = 1'b0;
    exp_led     = 1'b0;
    exp_addr    = '0;
    exp_data    = '0;
  endtask

  task automatic model_edge(input logic dv, input logic [7:0] b);
    edge_n++;
    exp_wr_en = 1'b0;
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    if (dv) begin
      last_strobe = edge_n;
      gap         = 0;
      if (have < 2) begin
        pend[have] = b;
        have++;
      end else begin
        exp_wr_en = 1'b1;
        exp_addr  = AW'(pix);
        exp_data  = {pend[0][7:4], pend[1][7:4], b[7:4]};
        exp_done  = (pix == N - 1);
        pix       = (pix + 1) % N;
        have      = 0;
      end
    end else if (have > 0) begin
      gap++;
      if (gap == TMO) begin
        exp_err = 1'b1;
        have    = 0;
        gap     = 0;
      end
    end
    exp_busy = (pix != 0) || (have != 0);
    exp_led  = (edge_n - last_strobe) < HOLD;
  endtask

  task automatic check_all();
    check_eq("wr_en", 32'(wr_en), 32'(exp_wr_en));
    check_eq("wr_addr", 32'(wr_addr), 32'(exp_addr));
    check_eq("wr_data", 32'(wr_data), 32'(exp_data));
    check_eq("frame_done", 32'(frame_done), 32'(exp_done));
    check_eq("sync_err", 32'(sync_err), 32'(exp_err));
    check_eq("busy", 32'(busy), 32'(exp_busy));
    check_eq("rx_led", 32'(rx_led), 32'(exp_led));
  endtask

  // Called at a negedge: drive, clock once, update the model, compare at the next negedge.
  task automatic cycle(input logic dv, input logic [7:0] b);
    rx_dv   = dv;
    rx_byte = dv ? b : 8'($urandom);
    @(posedge clk);
    model_edge(dv, b);
    @(negedge clk);
    rx_dv = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
  endtask

  task automatic send_byte(input logic [7:0] b);
    cycle(1'b1, b);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    rst_n       = 1'b1;
    rx_dv       = 1'b0;
    rx_byte     = 8'h00;
    edge_n      = 0;
    model_reset();
    @(negedge clk);
    apply_reset();

    // Single pixel F0,80,1F.
    send_byte(8'hF0);
    send_byte(8'h80);
    send_byte(8'h1F);
    check_eq("pix0_wr_en", 32'(wr_en), 32'd1);
    check_eq("pix0_addr", 32'(wr_addr), 32'd0);
    check_eq("pix0_data", 32'(wr_data), 32'hF81);
    idle(3);

    // Full frame back-to-back from a fresh reset, then one more pixel at address 0.
    apply_reset();
    for (int i = 0; i < 3 * N; i++) send_byte(8'($urandom));
    idle(2);
    check_eq("frame_busy_clear", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    check_eq("wrap_addr", 32'(wr_addr), 32'd0);
    idle(2);

    // Timeout after R,G with 50 idle clocks.
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    idle(TMO);
    check_eq("timeout_err", 32'(sync_err), 32'd1);
    idle(3);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    check_eq("after_timeout_addr", 32'(wr_addr), 32'd1);

    // Strobe on the expiry cycle is taken as B.
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    idle(TMO - 1);
    send_byte(8'($urandom));
    check_eq("edge_strobe_write", 32'(wr_en), 32'd1);
    check_eq("edge_strobe_noerr", 32'(sync_err), 32'd0);
    idle(3);

    // Reset mid-frame after 2 bytes of pixel 3.
    apply_reset();
    for (int i = 0; i < 3 * 3 + 2; i++) send_byte(8'($urandom));
    apply_reset();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    check_eq("post_reset_addr", 32'(wr_addr), 32'd0);

    // LED stretch with two strobes 10 clocks apart.
    idle(HOLD + TMO + 5);
    send_byte(8'($urandom));
    idle(9);
    send_byte(8'($urandom));
    idle(HOLD - 1);
    check_eq("led_still_on", 32'(rx_led), 32'd1);
    idle(1);
    check_eq("led_off", 32'(rx_led), 32'd0);
    idle(TMO + 5);

    // Random traffic with mostly short gaps and occasional near-timeout gaps.
    for (int i = 0; i < 600; i++) begin
      int sel;
      send_byte(8'($urandom));
      sel = int'($urandom_range(0, 9));
      if (sel == 0) idle(int'($urandom_range(TMO - 2, TMO + 2)));
      else if (sel < 4) idle(int'($urandom_range(1, 4)));
      if ($urandom_range(0, 199) == 0) apply_reset();
    end
    idle(TMO + HOLD);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
